// File: rtl/accum_burst_ctrl.sv
// accum_burst_ctrl: burst accumulator controller with sticky carry/borrow and overflow flags
module accum_burst_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_sum,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t           state;
   logic [N-1:0]     acc;
   logic [N-1:0]     op;
   logic [N-1:0]     res;
   logic [CNT_W-1:0] remaining;
   logic             sub_q;
   logic             c;
   logic             ovf;
   logic             xfer;
   assign out_sum = acc;
   // Subtraction is add of the inverted operand with carry-in; overflow when like-signed inputs give an unlike-signed result
   always_comb begin
      op       = sub_q ? ~in_data : in_data;
      {c, res} = {1'b0, acc} + {1'b0, op} + {{N{1'b0}}, sub_q};
      ovf      = (acc[N-1] == op[N-1]) && (res[N-1] != acc[N-1]);
      xfer     = in_valid & in_ready;
   end
   // Burst sequencer with accumulator, remaining count, sticky flags and registered handshake outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         sub_q     <= 1'b0;
         out_carry <= 1'b0;
         out_ovf   <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               sub_q     <= sub;
               acc       <= '0;
               out_carry <= 1'b0;
               out_ovf   <= 1'b0;
               busy      <= 1'b1;
               remaining <= len;
               if (len == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  state    <= ACCUM;
                  in_ready <= 1'b1;
               end
            end
            ACCUM: if (xfer) begin
               acc       <= res;
               out_carry <= out_carry | (c ^ sub_q);
               out_ovf   <= out_ovf | ovf;
               remaining <= remaining - 1'b1;
               if (remaining == CNT_W'(1)) begin
                  state     <= DONE;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule
